// File: rtl/spi_reg_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : spi_reg_responder
// Brief    : SPI mode-0 slave giving the HPS SPI master access to fabric
//            control (R/W) and status (R/O) byte registers. SCLK is oversampled.
//            Optional burst auto-increment: define SPI_REG_RESPONDER_AUTOINC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_responder #(
    parameter int NUM_REGS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [NUM_REGS*8-1:0] stat_in,
    output logic [NUM_REGS*8-1:0] ctrl_out,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic                  busy
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CMD    = 2'd1;
    localparam logic [1:0] c_ST_DATA   = 2'd2;
    localparam logic [1:0] c_ST_IGNORE = 2'd3;

    logic                  r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic                  r_mosi_meta, r_mosi_sync;
    logic                  r_cs_meta, r_cs_sync;
    logic                  r_cs_mask;
    logic [1:0]            r_state;
    logic [2:0]            r_bit_cnt;
    logic [6:0]            r_rx;
    logic [6:0]            r_tx;
    logic                  r_rw;
    logic [6:0]            r_addr;
    logic [NUM_REGS*8-1:0] r_ctrl;
    logic                  r_miso;
    logic                  r_wr_strobe;
    logic [6:0]            r_wr_addr;

    logic                  w_sclk_rise, w_sclk_fall, w_selected;
    logic [7:0]            w_rx_byte;
    logic [7:0]            w_cmd_rdata;
    logic                  w_addr_is_ctrl;

    function automatic logic [7:0] read_byte(input logic [6:0]            a,
                                             input logic [NUM_REGS*8-1:0] ctrl,
                                             input logic [NUM_REGS*8-1:0] stat);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (a == 7'(k))
                v = ctrl[8*k +: 8];
            if (a == 7'(k + 64))
                v = stat[8*k +: 8];
        end
        return v;
    endfunction

    // Synchronizers keep tracking the pins through reset so that a frame
    // already in progress at reset release is not mistaken for a new one.
    always_ff @(posedge clk) begin
        r_sclk_meta <= spi_sclk;
        r_sclk_sync <= r_sclk_meta;
        r_sclk_prev <= r_sclk_sync;
        r_mosi_meta <= spi_mosi;
        r_mosi_sync <= r_mosi_meta;
        r_cs_meta   <= spi_cs_n;
        r_cs_sync   <= r_cs_meta;
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
    assign w_selected  = ~r_cs_sync & ~r_cs_mask;
    assign w_rx_byte   = {r_rx, r_mosi_sync};
    assign w_cmd_rdata = read_byte(w_rx_byte[6:0], r_ctrl, stat_in);

`ifdef SPI_REG_RESPONDER_AUTOINC_EN
    logic [6:0] w_next_addr;
    logic [7:0] w_next_rdata;
    assign w_next_addr  = r_addr + 7'd1;
    assign w_next_rdata = read_byte(w_next_addr, r_ctrl, stat_in);
`endif

    always_comb begin
        w_addr_is_ctrl = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (r_addr == 7'(k))
                w_addr_is_ctrl = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx        <= 7'd0;
            r_tx        <= 7'd0;
            r_rw        <= 1'b0;
            r_addr      <= 7'd0;
            r_ctrl      <= '0;
            r_miso      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 7'd0;
            r_cs_mask   <= 1'b1;
        end else begin
            r_wr_strobe <= 1'b0;
            if (r_cs_sync)
                r_cs_mask <= 1'b0;

            if (!w_selected) begin
                r_state   <= c_ST_IDLE;
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_state   <= c_ST_CMD;
                        r_bit_cnt <= 3'd0;
                        r_rx      <= 7'd0;
                        r_tx      <= 7'd0;
                        r_miso    <= 1'b0;
                    end
                    c_ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_rx      <= w_rx_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_rw    <= w_rx_byte[7];
                                r_addr  <= w_rx_byte[6:0];
                                r_tx    <= w_rx_byte[7] ? w_cmd_rdata[6:0] : 7'd0;
                                r_miso  <= w_rx_byte[7] & w_cmd_rdata[7];
                                r_state <= c_ST_DATA;
                            end
                        end
                    end
                    c_ST_DATA: begin
                        if (w_sclk_rise) begin
                            r_rx      <= w_rx_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (!r_rw && w_addr_is_ctrl) begin
                                    for (int k = 0; k < NUM_REGS; k++) begin
                                        if (r_addr == 7'(k))
                                            r_ctrl[8*k +: 8] <= w_rx_byte;
                                    end
                                    r_wr_strobe <= 1'b1;
                                    r_wr_addr   <= r_addr;
                                end
`ifdef SPI_REG_RESPONDER_AUTOINC_EN
                                r_addr <= w_next_addr;
                                r_tx   <= r_rw ? w_next_rdata[6:0] : 7'd0;
                                r_miso <= r_rw & w_next_rdata[7];
`else
                                r_state <= c_ST_IGNORE;
                                r_tx    <= 7'd0;
                                r_miso  <= 1'b0;
`endif
                            end
                        end else if (w_sclk_fall && r_bit_cnt != 3'd0) begin
                            // The fall right after a byte load must not shift:
                            // the MSB has to be held for the next rise.
                            r_miso <= r_tx[6];
                            r_tx   <= {r_tx[5:0], 1'b0};
                        end
                    end
                    default: begin
                        r_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = w_selected;
    assign busy        = w_selected;
    assign ctrl_out    = r_ctrl;
    assign wr_strobe   = r_wr_strobe;
    assign wr_addr     = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_reg_responder
// Brief    : Directed plus randomized frames for spi_reg_responder, checked
//            against a byte-level register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_responder;

    localparam int NR   = 4;
    localparam int HALF = 8;
`ifdef SPI_REG_RESPONDER_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            spi_sclk = 1'b0;
    logic            spi_mosi = 1'b0;
    logic            spi_cs_n = 1'b1;
    logic            spi_miso, spi_miso_oe, wr_strobe, busy;
    logic [NR*8-1:0] stat_in = '0;
    logic [NR*8-1:0] ctrl_out;
    logic [6:0]      wr_addr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_ctrl [NR];
    logic [7:0] m_stat [NR];
    logic [7:0] tx_bytes [4];
    logic [7:0] exp_rx [4];
    logic [6:0] exp_q [$];
    logic [6:0] got_q [$];

    spi_reg_responder #(.NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .stat_in(stat_in), .ctrl_out(ctrl_out), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1)
            got_q.push_back(wr_addr);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (int'(a) < NR)
            return m_ctrl[int'(a)];
        if (int'(a) >= 64 && int'(a) < 64 + NR)
            return m_stat[int'(a) - 64];
        return 8'h00;
    endfunction

    task automatic set_stat();
        for (int k = 0; k < NR; k++)
            stat_in[8*k +: 8] = m_stat[k];
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NR; k++)
            check($sformatf("%s_ctrl%0d", tag, k), {24'd0, ctrl_out[8*k +: 8]}, {24'd0, m_ctrl[k]});
    endtask

    task automatic check_strobes(input string tag);
        check($sformatf("%s_strobe_count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_wr_addr%0d", tag, i), {25'd0, got_q[i]}, {25'd0, exp_q[i]});
    endtask

    // Shifts out the top nb bits of tx; master samples MISO just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nb; i--) begin
            spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    // Full frame: tx_bytes[0] is the command, tx_bytes[1..nd] data bytes.
    task automatic run_txn(input string tag, input int nd);
        logic       rw;
        logic [6:0] a, ai;
        logic [7:0] rx;
        rw = tx_bytes[0][7];
        a  = tx_bytes[0][6:0];
        exp_q.delete();
        got_q.delete();
        exp_rx[0] = 8'h00;
        for (int i = 1; i <= nd; i++) begin
            exp_rx[i] = 8'h00;
            if (i == 1 || AUTOINC) begin
                ai = a + 7'(i - 1);
                if (rw)
                    exp_rx[i] = model_read(ai);
                else if (int'(ai) < NR) begin
                    m_ctrl[int'(ai)] = tx_bytes[i];
                    exp_q.push_back(ai);
                end
            end
        end
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_oe"}, {31'd0, spi_miso_oe}, 32'd1);
        for (int i = 0; i <= nd; i++) begin
            spi_bits(tx_bytes[i], 8, rx);
            check($sformatf("%s_rx%0d", tag, i), {24'd0, rx}, {24'd0, exp_rx[i]});
        end
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        check({tag, "_oe_off"}, {31'd0, spi_miso_oe}, 32'd0);
        check_strobes(tag);
        check_regs(tag);
    endtask

    initial begin
        logic [7:0] rx;
        int         kind;
        for (int k = 0; k < NR; k++) begin
            m_ctrl[k] = 8'h00;
            m_stat[k] = 8'h00;
        end
        set_stat();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_regs("reset");
        check("reset_miso", {31'd0, spi_miso}, 32'd0);
        check("reset_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("reset_strobe", {31'd0, wr_strobe}, 32'd0);
        check("reset_wr_addr", {25'd0, wr_addr}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        tx_bytes[0] = 8'h01; tx_bytes[1] = 8'hA5;
        run_txn("wr01", 1);

        m_stat[0] = 8'h3C; set_stat();
        tx_bytes[0] = 8'hC0; tx_bytes[1] = 8'h00;
        run_txn("rd40", 1);

        tx_bytes[0] = 8'h41; tx_bytes[1] = 8'hFF;
        run_txn("wr41", 1);
        tx_bytes[0] = 8'hFF; tx_bytes[1] = 8'h00;
        run_txn("rd7f", 1);

        // Frame aborted after 5 data bits
        got_q.delete(); exp_q.delete();
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h55, 5, rx);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check_strobes("abort");
        check_regs("abort");
        tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h11;
        run_txn("wr02", 1);

        tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h10; tx_bytes[2] = 8'h20; tx_bytes[3] = 8'h30;
        run_txn("burst", 3);

        // Reset in the middle of a data byte
        got_q.delete(); exp_q.delete();
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(8'h03, 8, rx);
        spi_bits(8'hEE, 4, rx);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NR; k++) m_ctrl[k] = 8'h00;
        check("rstmid_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("rstmid_miso", {31'd0, spi_miso}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check_regs("rstmid");
        reset = 1'b0;
        spi_bits(8'hE0, 4, rx);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check_strobes("rstmid_after");
        check_regs("rstmid_after");
        tx_bytes[0] = 8'h03; tx_bytes[1] = 8'h77;
        run_txn("post_rst_wr", 1);
        tx_bytes[0] = 8'h83; tx_bytes[1] = 8'h00;
        run_txn("post_rst_rd", 1);

        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < NR; k++) m_stat[k] = 8'($urandom);
            set_stat();
            kind = int'($urandom_range(0, 2));
            if (kind == 0)
                tx_bytes[0][6:0] = 7'($urandom_range(0, NR - 1));
            else if (kind == 1)
                tx_bytes[0][6:0] = 7'(64 + $urandom_range(0, NR - 1));
            else
                tx_bytes[0][6:0] = 7'($urandom_range(0, 127));
            tx_bytes[0][7] = 1'($urandom_range(0, 1));
            for (int i = 1; i < 4; i++) tx_bytes[i] = 8'($urandom);
            run_txn($sformatf("rand%0d", n), int'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
